// File: rtl/section_min_max_span_pkg.sv
// Shared helpers for the section min/max span pipeline.
package section_min_max_span_pkg;

   // Index width that stays at least one bit wide, even for single-entry structures.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/section_min_max.sv
// Section stage: folds sample_count accepted samples into one registered min/max pair
// and offers it downstream with a valid/ready handshake.
module section_min_max
   import section_min_max_span_pkg::*;
#(
   parameter int unsigned width        = 16,
   parameter int unsigned sample_count = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [width-1:0] i_value,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [width-1:0] o_min_value,
   output logic [width-1:0] o_max_value
);

   localparam int unsigned CntW = idx_width(sample_count);

   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [width-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
   logic [width-1:0] sec_min_q, sec_min_d, sec_max_q, sec_max_d;
   logic             sec_valid_q, sec_valid_d;
   logic             accept, last, take;

   // A pending section blocks new samples until the buffer stage takes it.
   assign i_ready = !reset && (!sec_valid_q || o_ready);
   assign accept  = i_valid && i_ready;
   assign take    = sec_valid_q && o_ready;
   assign last    = (cnt_q == CntW'(sample_count - 1));

   always_comb begin
      cnt_d       = cnt_q;
      run_min_d   = run_min_q;
      run_max_d   = run_max_q;
      sec_min_d   = sec_min_q;
      sec_max_d   = sec_max_q;
      sec_valid_d = sec_valid_q;
      if (take) sec_valid_d = 1'b0;
      if (accept) begin
         if (cnt_q == '0) begin
            run_min_d = i_value;
            run_max_d = i_value;
         end else begin
            if (i_value < run_min_q) run_min_d = i_value;
            if (i_value > run_max_q) run_max_d = i_value;
         end
         if (last) begin
            cnt_d       = '0;
            sec_valid_d = 1'b1;
            sec_min_d   = run_min_d;
            sec_max_d   = run_max_d;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         run_min_q   <= '0;
         run_max_q   <= '0;
         sec_min_q   <= '0;
         sec_max_q   <= '0;
         sec_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         run_min_q   <= run_min_d;
         run_max_q   <= run_max_d;
         sec_min_q   <= sec_min_d;
         sec_max_q   <= sec_max_d;
         sec_valid_q <= sec_valid_d;
      end
   end

   assign o_valid     = sec_valid_q;
   assign o_min_value = sec_min_q;
   assign o_max_value = sec_max_q;

endmodule

// File: rtl/section_min_max_span.sv
// Span (max - min) over the last buffer_depth sections, kept in a ring of per-section
// min/max pairs and published through a registered valid/ready output.
module section_min_max_span
   import section_min_max_span_pkg::*;
#(
   parameter int unsigned width        = 16,
   parameter int unsigned sample_count = 4,
   parameter int unsigned buffer_depth = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [width-1:0] i_value,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [width-1:0] o_value
);

   localparam int unsigned PtrW = idx_width(buffer_depth);
   localparam int unsigned OccW = idx_width(buffer_depth + 1);

   logic             sec_valid, sec_ready, take;
   logic [width-1:0] sec_min, sec_max;
   logic [width-1:0] slot_min_q [buffer_depth];
   logic [width-1:0] slot_max_q [buffer_depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [OccW-1:0]  occ_q, occ_d;
   logic [width-1:0] span_min, span_max;
   logic [width-1:0] o_value_q, o_value_d;
   logic             o_valid_q, o_valid_d;

   section_min_max #(
      .width       (width),
      .sample_count(sample_count)
   ) u_section (
      .clk        (clk),
      .reset      (reset),
      .i_valid    (i_valid),
      .i_ready    (i_ready),
      .i_value    (i_value),
      .o_valid    (sec_valid),
      .o_ready    (sec_ready),
      .o_min_value(sec_min),
      .o_max_value(sec_max)
   );

   assign sec_ready = !o_valid_q || o_ready;
   assign take      = sec_valid && sec_ready;

   // The slot under the write pointer is either empty or the oldest entry being
   // evicted, so the incoming section stands in for it.
   always_comb begin
      span_min = sec_min;
      span_max = sec_max;
      for (int unsigned i = 0; i < buffer_depth; i++) begin
         if ((OccW'(i) < occ_q) && (PtrW'(i) != wr_ptr_q)) begin
            if (slot_min_q[i] < span_min) span_min = slot_min_q[i];
            if (slot_max_q[i] > span_max) span_max = slot_max_q[i];
         end
      end
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      occ_d     = occ_q;
      o_value_d = o_value_q;
      o_valid_d = o_valid_q && !o_ready;
      if (take) begin
         wr_ptr_d  = (wr_ptr_q == PtrW'(buffer_depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
         occ_d     = (occ_q == OccW'(buffer_depth)) ? occ_q : occ_q + OccW'(1);
         o_value_d = span_max - span_min;
         o_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         occ_q     <= '0;
         o_value_q <= '0;
         o_valid_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         occ_q     <= occ_d;
         o_value_q <= o_value_d;
         o_valid_q <= o_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (take) begin
         slot_min_q[wr_ptr_q] <= sec_min;
         slot_max_q[wr_ptr_q] <= sec_max;
      end
   end

   assign o_valid = o_valid_q;
   assign o_value = o_value_q;

endmodule

// File: tb/tb_section_min_max_span.sv
// Scoreboard bench: driver feeds sections into a queue-based reference model, and a
// negedge monitor pops and compares each accepted output.
module tb_section_min_max_span;

   localparam int unsigned W  = 16;
   localparam int unsigned SC = 4;
   localparam int unsigned BD = 4;

   logic         clk     = 1'b0;
   logic         reset   = 1'b1;
   logic         i_valid = 1'b0;
   logic [W-1:0] i_value = '0;
   logic         o_ready = 1'b1;
   logic         i_ready, o_valid;
   logic [W-1:0] o_value;

   int checks   = 0;
   int failures = 0;
   int bp_mode  = 0;  // 0: ready, 1: stalled, 2: random

   logic [W-1:0] exp_q[$];
   logic [W-1:0] hist_min[$];
   logic [W-1:0] hist_max[$];
   logic [W-1:0] part[$];

   always #5 clk = ~clk;

   section_min_max_span #(
      .width       (W),
      .sample_count(SC),
      .buffer_depth(BD)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .i_valid(i_valid),
      .i_ready(i_ready),
      .i_value(i_value),
      .o_valid(o_valid),
      .o_ready(o_ready),
      .o_value(o_value)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      part.delete();
      hist_min.delete();
      hist_max.delete();
      exp_q.delete();
   endtask

   // Reference: span of the last BD complete sections, from plain queue arithmetic.
   task automatic model_accept(input logic [W-1:0] v);
      logic [W-1:0] mn, mx;
      part.push_back(v);
      if (part.size() == SC) begin
         mn = part[0];
         mx = part[0];
         foreach (part[k]) begin
            if (part[k] < mn) mn = part[k];
            if (part[k] > mx) mx = part[k];
         end
         hist_min.push_back(mn);
         hist_max.push_back(mx);
         if (hist_min.size() > BD) begin
            void'(hist_min.pop_front());
            void'(hist_max.pop_front());
         end
         mn = hist_min[0];
         mx = hist_max[0];
         foreach (hist_min[k]) begin
            if (hist_min[k] < mn) mn = hist_min[k];
            if (hist_max[k] > mx) mx = hist_max[k];
         end
         exp_q.push_back(mx - mn);
         part.delete();
      end
   endtask

   task automatic send(input logic [W-1:0] v);
      int n = 0;
      @(negedge clk);
      i_valid = 1'b1;
      i_value = v;
      while (!i_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!i_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: i_ready got 0 required 1");
         i_valid = 1'b0;
         return;
      end
      @(posedge clk);
      model_accept(v);
      #1 i_valid = 1'b0;
   endtask

   task automatic send_const(input logic [W-1:0] v);
      for (int k = 0; k < SC; k++) send(v);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: pending got %0d required 0", exp_q.size());
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_o_valid", W'(o_valid), W'(0));
      check("reset_i_ready", W'(i_ready), W'(0));
      check("reset_o_value", o_value, '0);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", W'(i_ready), W'(1));
   endtask

   // Only writer of o_ready; changes land well after the rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (bp_mode)
            0:       o_ready = 1'b1;
            1:       o_ready = 1'b0;
            default: o_ready = ($urandom_range(3, 0) != 0);
         endcase
      end
   end

   initial begin
      bit           held = 1'b0;
      logic [W-1:0] held_val = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("hold_valid", W'(o_valid), W'(1));
               check("hold_value", o_value, held_val);
            end
            if (o_valid && o_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output: got %h required none", o_value);
               end else begin
                  check("span", o_value, exp_q.pop_front());
               end
            end
            held     = o_valid && !o_ready;
            held_val = o_value;
         end
      end
   end

   initial begin
      logic [W-1:0] dir_vals[] = '{16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h2222,
                                   16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777,
                                   16'h8888, 16'h9999, 16'hFFFF, 16'h1111};
      logic [W-1:0] lo, hi;

      repeat (3) @(negedge clk);
      check("reset_o_valid", W'(o_valid), W'(0));
      check("reset_i_ready", W'(i_ready), W'(0));
      check("reset_o_value", o_value, '0);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", W'(i_ready), W'(1));

      foreach (dir_vals[k]) send_const(dir_vals[k]);
      drain();

      // Mixed section, then output stall with a second section behind it.
      do_reset();
      bp_mode = 1;
      send(16'd5);
      send(16'd1);
      send(16'd9);
      send(16'd3);
      repeat (4) @(negedge clk);
      check("stall_o_valid", W'(o_valid), W'(1));
      for (int k = 0; k < SC; k++) send(W'($urandom_range(16'hFFFF, 0)));
      repeat (3) @(negedge clk);
      check("stall_i_ready", W'(i_ready), W'(0));
      bp_mode = 0;
      drain();

      // Reset mid-section discards the partial and all buffered sections.
      send(16'h0100);
      send(16'hF000);
      do_reset();
      send_const(16'd7);
      drain();

      bp_mode = 2;
      for (int s = 0; s < 40; s++) begin
         lo = W'($urandom_range(16'hFFFF, 0));
         hi = W'($urandom_range(16'hFFFF, 0));
         if (lo > hi) begin
            lo = lo ^ hi;
            hi = lo ^ hi;
            lo = lo ^ hi;
         end
         for (int k = 0; k < SC; k++) begin
            send(W'($urandom_range(hi, lo)));
            if ($urandom_range(3, 0) == 0) @(negedge clk);
         end
      end
      bp_mode = 0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
